fpu_issue_seq: RTL
==================

# fpu_issue_seq

Multi-cycle FPU issue/retire sequencer between the execute stage and the register-file writeback port. The decode stage issues one float operation together with its decoded `fpu_cont` code and `fpu_stall` latency. This block then:

- latches the operands and operation code and holds them stable at the FPU inputs,
- counts down the decoded latency while asserting a pipeline stall,
- captures the FPU result,
- presents the result to writeback with a valid/ready handshake, tagged with the destination register and register file (integer or float).

## Interface

Parameters:
- `CNT_W`, 4: width of the latency counter; matches the `fpu_stall` field.
- `OPS_W`, 16: width of the retired-operation counter.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `issue_valid`  in  1: execute stage presents a float operation this cycle.
- `issue_ready`  out  1: sequencer accepts the operation this cycle.
- `issue_cont`  in  5: FPU operation code (0x10–0x1D).
- `issue_stall`  in  CNT_W: decoded latency N, range 0–15.
- `issue_x1`, `issue_x2`  in  32 each: source operands.
- `issue_rd`  in  5: destination register index.
- `issue_rd_float`  in  1: 1 = float register file, 0 = integer register file (compare ops, fcvt.w.s).
- `fpu_x1`, `fpu_x2`  out  32 each: latched operands driven to the FPU.
- `fpu_cont`  out  5: latched operation code driven to the FPU.
- `fpu_y`  in  32: FPU result.
- `pipe_stall`  out  1: freeze the upstream pipeline.
- `flush`  in  1: kill the in-flight operation (branch mispredict or trap).
- `wb_valid`  out  1: result available.
- `wb_ready`  in  1: writeback port accepts the result.
- `wb_data`  out  32: result value.
- `wb_rd`  out  5: destination register index.
- `wb_float`  out  1: destination register file, same encoding as `issue_rd_float`.
- `ops_retired`  out  OPS_W: count of results accepted by writeback.

## Operation

States: IDLE, BUSY, DONE.

- **IDLE**
  - `issue_ready` = 1.
  - On `issue_valid`: latch x1, x2, cont, rd, rd_float; set `cnt` = `issue_stall`; go to BUSY.
- **BUSY**
  - `fpu_x1`, `fpu_x2`, `fpu_cont` stay constant.
  - If `cnt` != 0: decrement `cnt`.
  - If `cnt` == 0: capture `fpu_y` into `wb_data`; go to DONE.
- **DONE**
  - `wb_valid` = 1; `wb_data`, `wb_rd`, `wb_float` stay stable until accepted.
  - On `wb_valid && wb_ready`: increment `ops_retired` (wraps modulo 2^OPS_W).
  - If `issue_valid` in the same cycle, latch the new operation and go to BUSY. Otherwise go to IDLE.
- **Handshake signals**
  - `issue_ready` = IDLE or (DONE and `wb_ready`).
  - `pipe_stall` = (state == BUSY) or (DONE and not `wb_ready`).
- **Flush**
  - In BUSY or DONE: go to IDLE; `wb_valid` drops next cycle; `ops_retired` unchanged.
  - Flush has priority over capture, retire and issue in the same cycle.
  - An `issue_valid` coincident with `flush` is not accepted.
- **Decode rules**
  - `issue_cont` is passed through without decoding.
  - Unsupported codes still run N cycles; their result is whatever `fpu_y` returns (0).

## Timing

- **Reset values**: state IDLE, `issue_ready` 1, `pipe_stall` 0, `wb_valid` 0, `wb_data`/`wb_rd`/`wb_float` 0, `fpu_x1`/`fpu_x2`/`fpu_cont` 0, `ops_retired` 0.
- **Reset mid-operation**: immediate return to the reset values above; no partial writeback.
- **Latency**: issue accepted at edge T → `fpu_*` valid from T → result captured at edge T+N+1 → `wb_valid` high from T+N+1.
  - N=0: `wb_valid` one cycle after issue. N=15: 16 cycles after issue.
- **Throughput**: with `wb_ready` held high, one operation every N+2 cycles (issue edge plus N+1 BUSY cycles).
- **Counter**: `cnt` never underflows; the decrement happens only when `cnt` != 0.
- **Back-pressure**: `wb_ready` low holds DONE indefinitely with outputs stable; `pipe_stall` stays high.

## Test plan

- **fadd, full latency**: issue cont=0x10, N=5, x1=0x3F800000, x2=0x40000000, rd=3, rd_float=1; FPU model returns 0x40400000 → `wb_valid` 6 cycles after issue, `wb_data`=0x40400000, `wb_rd`=3, `wb_float`=1, `pipe_stall` high for 6 cycles, `ops_retired`=1.
- **flt, zero latency**: cont=0x16, N=0, rd_float=0 → `wb_valid` 1 cycle after issue, `wb_float`=0, `pipe_stall` high for exactly 1 cycle.
- **Back-pressure then back-to-back**: fdiv N=7 with `wb_ready`=0 for 4 cycles after `wb_valid` → outputs stable and `pipe_stall`=1 throughout. Then `wb_ready`=1 together with a new `issue_valid` → retire and issue in the same cycle, state goes to BUSY, `ops_retired` increments by 1.
- **Flush**: flush 2 cycles into an N=5 fmul → IDLE next cycle, `wb_valid` never asserts, `ops_retired` unchanged. Flush coincident with `issue_valid` → no issue accepted.
- **Reset mid-operation**: assert `rst` asynchronously (mid-cycle, not on an edge) during BUSY with `cnt`=3 → all outputs at reset values before the next edge; a following issue behaves normally.
- **Counter wrap**: preload via 65536 retirements (or OPS_W=4 with 16) → `ops_retired` returns to 0.

Source files
------------

// File: rtl/fpu_issue_seq_if.sv
// Handshake bundle between execute, the FPU datapath and writeback for fpu_issue_seq.
// The slave modport is the sequencer view; master is the surrounding pipeline/FPU view.
interface fpu_issue_seq_if #(
    parameter int unsigned CNT_W = 4,
    parameter int unsigned OPS_W = 16
);
    logic             issue_valid;
    logic             issue_ready;
    logic [4:0]       issue_cont;
    logic [CNT_W-1:0] issue_stall;
    logic [31:0]      issue_x1;
    logic [31:0]      issue_x2;
    logic [4:0]       issue_rd;
    logic             issue_rd_float;
    logic [31:0]      fpu_x1;
    logic [31:0]      fpu_x2;
    logic [4:0]       fpu_cont;
    logic [31:0]      fpu_y;
    logic             pipe_stall;
    logic             flush;
    logic             wb_valid;
    logic             wb_ready;
    logic [31:0]      wb_data;
    logic [4:0]       wb_rd;
    logic             wb_float;
    logic [OPS_W-1:0] ops_retired;

    modport slave (
        input  issue_valid, issue_cont, issue_stall, issue_x1, issue_x2,
               issue_rd, issue_rd_float, fpu_y, flush, wb_ready,
        output issue_ready, fpu_x1, fpu_x2, fpu_cont, pipe_stall,
               wb_valid, wb_data, wb_rd, wb_float, ops_retired
    );

    modport master (
        output issue_valid, issue_cont, issue_stall, issue_x1, issue_x2,
               issue_rd, issue_rd_float, fpu_y, flush, wb_ready,
        input  issue_ready, fpu_x1, fpu_x2, fpu_cont, pipe_stall,
               wb_valid, wb_data, wb_rd, wb_float, ops_retired
    );
endinterface

// File: rtl/fpu_issue_seq.sv
// Multi-cycle FPU issue/retire sequencer: holds operands for the decoded latency,
// captures the FPU result and hands it to writeback with a valid/ready handshake.
module fpu_issue_seq #(
    parameter int unsigned CNT_W = 4,
    parameter int unsigned OPS_W = 16
) (
    input logic           clk,
    input logic           rst,
    fpu_issue_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      x1_q, x1_d;
    logic [31:0]      x2_q, x2_d;
    logic [4:0]       cont_q, cont_d;
    logic [4:0]       rd_q, rd_d;
    logic             flt_q, flt_d;
    logic [31:0]      data_q, data_d;
    logic [OPS_W-1:0] ops_q, ops_d;

    logic issue_ready;
    logic accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x1_q    <= '0;
            x2_q    <= '0;
            cont_q  <= '0;
            rd_q    <= '0;
            flt_q   <= 1'b0;
            data_q  <= '0;
            ops_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            cont_q  <= cont_d;
            rd_q    <= rd_d;
            flt_q   <= flt_d;
            data_q  <= data_d;
            ops_q   <= ops_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        cont_d  = cont_q;
        rd_d    = rd_q;
        flt_d   = flt_q;
        data_d  = data_q;
        ops_d   = ops_q;

        issue_ready = (state_q == IDLE) || ((state_q == DONE) && bus.wb_ready);
        accept      = bus.issue_valid && issue_ready && !bus.flush;

        case (state_q)
            IDLE: ;
            BUSY: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    data_d  = bus.fpu_y;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (bus.wb_ready) begin
                    ops_d   = ops_q + OPS_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Accept implies no flush, and in DONE also a retire, so it can override the case result.
        if (accept) begin
            x1_d    = bus.issue_x1;
            x2_d    = bus.issue_x2;
            cont_d  = bus.issue_cont;
            rd_d    = bus.issue_rd;
            flt_d   = bus.issue_rd_float;
            cnt_d   = bus.issue_stall;
            state_d = BUSY;
        end
    end

    assign bus.issue_ready = issue_ready;
    assign bus.pipe_stall  = (state_q == BUSY) || ((state_q == DONE) && !bus.wb_ready);
    assign bus.wb_valid    = (state_q == DONE);
    assign bus.fpu_x1      = x1_q;
    assign bus.fpu_x2      = x2_q;
    assign bus.fpu_cont    = cont_q;
    assign bus.wb_data     = data_q;
    assign bus.wb_rd       = rd_q;
    assign bus.wb_float    = flt_q;
    assign bus.ops_retired = ops_q;

endmodule
